// File: rtl/vga_frame_monitor.sv
// Receive-side VGA timing/content monitor: recovers pixel coordinates, checks
// line/frame geometry, checksums each frame and captures one chosen pixel.
module vga_frame_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        iRST_n,
  input  logic        iVGA_CLK,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK_n,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  input  logic [9:0]  sample_x,
  input  logic [8:0]  sample_y,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_valid,
  output logic [23:0] pix_rgb,
  output logic        frame_done,
  output logic [23:0] frame_sum,
  output logic [9:0]  frame_lines,
  output logic [3:0]  frame_err,
  output logic [3:0]  err_sticky,
  output logic        locked,
  output logic [23:0] sample_rgb,
  output logic        sample_hit
);

  localparam int              LW         = $clog2(LOCK_FRAMES + 1);
  localparam logic [11:0]     H_TOTAL_C  = 12'(H_TOTAL);
  localparam logic [9:0]      H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [8:0]      V_ACTIVE_C = 9'(V_ACTIVE);
  localparam logic [9:0]      V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [LW-1:0]   LOCK_C     = LW'(LOCK_FRAMES);

  function automatic logic [10:0] inc_sat11(input logic [10:0] v);
    return (&v) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] inc_sat10(input logic [9:0] v);
    return (&v) ? v : v + 10'd1;
  endfunction

  function automatic logic [8:0] inc_sat9(input logic [8:0] v);
    return (&v) ? v : v + 9'd1;
  endfunction

  logic          hs_p0, vs_p0, blank_p0;
  logic          hs_p1, vs_p1, blank_p1;
  logic [23:0]   rgb_p0;

  logic [10:0]   hcnt;
  logic [9:0]    acnt;
  logic [8:0]    line_act;
  logic [9:0]    lcnt;
  logic [23:0]   sum;
  logic          err0_pend, err2_pend;
  logic          armed, first_line;
  logic [LW-1:0] lock_cnt;

  logic          line_start, frame_start, blank_fall;
  logic [11:0]   line_len;
  logic          len_bad, act_bad, pix_match;
  logic [9:0]    acnt_base;
  logic [3:0]    frame_errs;
  logic [LW-1:0] lock_nxt;

  // Stage 1: register the pins; a second copy gives the edge detectors
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hs_p0    <= 1'b0;
      vs_p0    <= 1'b0;
      blank_p0 <= 1'b0;
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
      blank_p1 <= 1'b0;
    end else begin
      hs_p0    <= iHS;
      vs_p0    <= iVS;
      blank_p0 <= iBLANK_n;
      hs_p1    <= hs_p0;
      vs_p1    <= vs_p0;
      blank_p1 <= blank_p0;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    rgb_p0 <= {iR, iG, iB};
  end

  always_comb begin
    line_start  = hs_p1 & ~hs_p0;
    frame_start = vs_p1 & ~vs_p0;
    blank_fall  = blank_p1 & ~blank_p0;
    line_len    = {1'b0, hcnt} + 12'd1;
    len_bad     = line_start & ~first_line & (line_len != H_TOTAL_C);
    act_bad     = blank_fall & (acnt != H_ACTIVE_C);
    acnt_base   = line_start ? 10'd0 : acnt;
    pix_match   = pix_valid & (pix_x == sample_x) & (pix_y == sample_y);
    // The line closed by an HS fall coincident with VS still belongs to the old frame
    frame_errs  = {lcnt != V_TOTAL_C, err2_pend | len_bad,
                   line_act != V_ACTIVE_C, err0_pend | act_bad};
    lock_nxt    = '0;
    if (frame_errs == 4'd0)
      lock_nxt = (lock_cnt == LOCK_C) ? lock_cnt : lock_cnt + LW'(1);
  end

  // Stage 2: counters, pixel outputs, frame results and sample capture
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hcnt        <= '0;
      acnt        <= '0;
      line_act    <= '0;
      lcnt        <= '0;
      sum         <= '0;
      err0_pend   <= 1'b0;
      err2_pend   <= 1'b0;
      armed       <= 1'b0;
      first_line  <= 1'b0;
      lock_cnt    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      frame_sum   <= '0;
      frame_lines <= '0;
      frame_err   <= '0;
      err_sticky  <= '0;
      locked      <= 1'b0;
      sample_rgb  <= '0;
      sample_hit  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sample_hit <= pix_match;
      if (pix_match)
        sample_rgb <= pix_rgb;

      pix_valid <= blank_p0;
      pix_rgb   <= rgb_p0;
      pix_x     <= acnt_base;
      pix_y     <= line_act;

      hcnt <= line_start ? 11'd0 : inc_sat11(hcnt);
      acnt <= blank_p0 ? inc_sat10(acnt_base) : acnt_base;

      if (frame_start) begin
        sum        <= blank_p0 ? rgb_p0 : 24'd0;
        line_act   <= '0;
        lcnt       <= line_start ? 10'd1 : 10'd0;
        err0_pend  <= 1'b0;
        err2_pend  <= 1'b0;
        armed      <= 1'b1;
        // hcnt is meaningless for the first line after (re)arming
        first_line <= ~armed;
        if (armed) begin
          frame_done  <= 1'b1;
          frame_sum   <= sum;
          frame_lines <= {1'b0, line_act};
          frame_err   <= frame_errs;
          err_sticky  <= err_sticky | frame_errs;
          lock_cnt    <= lock_nxt;
          locked      <= (lock_nxt == LOCK_C);
        end
      end else begin
        if (blank_p0)
          sum <= sum + rgb_p0;
        if (blank_fall)
          line_act <= inc_sat9(line_act);
        if (line_start) begin
          lcnt       <= inc_sat10(lcnt);
          first_line <= 1'b0;
        end
        if (act_bad)
          err0_pend <= 1'b1;
        if (len_bad)
          err2_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a reduced 24x12 (16x8 active)
// geometry so every scenario fits in a few thousand clocks.
module tb_vga_frame_monitor;

  localparam int HA = 16;
  localparam int VA = 8;
  localparam int HT = 24;
  localparam int VT = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b1, vs = 1'b1, blank = 1'b0;
  logic [23:0] rgb = 24'd0;
  logic [9:0]  sample_x = 10'd10;
  logic [8:0]  sample_y = 9'd5;
  logic        pat = 1'b0;

  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic        frame_done;
  logic [23:0] frame_sum;
  logic [9:0]  frame_lines;
  logic [3:0]  frame_err, err_sticky;
  logic        locked;
  logic [23:0] sample_rgb;
  logic        sample_hit;

  vga_frame_monitor #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .iRST_n(rst_n), .iVGA_CLK(clk), .iHS(hs), .iVS(vs), .iBLANK_n(blank),
    .iR(rgb[23:16]), .iG(rgb[15:8]), .iB(rgb[7:0]),
    .sample_x(sample_x), .sample_y(sample_y),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_sum(frame_sum), .frame_lines(frame_lines),
    .frame_err(frame_err), .err_sticky(err_sticky), .locked(locked),
    .sample_rgb(sample_rgb), .sample_hit(sample_hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          done_cnt = 0, hit_cnt = 0, hit_lat = 0, tgt_cyc = -100;
  logic [23:0] d_sum = '0, hit_rgb = '0, s_rgb = '0;
  logic [9:0]  d_lines = '0, s_x = '0;
  logic [8:0]  s_y = '0;
  logic [3:0]  d_err = '0, d_sticky = '0;
  logic        d_locked = 1'b0, s_valid = 1'b0;

  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt++;
      d_sum    = frame_sum;
      d_lines  = frame_lines;
      d_err    = frame_err;
      d_sticky = err_sticky;
      d_locked = locked;
    end
    if (sample_hit) begin
      hit_cnt++;
      hit_rgb = sample_rgb;
      hit_lat = cyc - tgt_cyc;
    end
    if (cyc == tgt_cyc + 2) begin
      s_valid = pix_valid;
      s_x     = pix_x;
      s_y     = pix_y;
      s_rgb   = pix_rgb;
    end
  end

  // mode: 0 nominal, 1 one active line short by a pixel, 2 HS dropped on line 6
  task automatic run_frame(input int mode, input int vs_off, input int rst_at);
    for (int l = 0; l < VT; l++) begin
      for (int h = 0; h < HT; h++) begin
        int   p;
        int   x;
        int   y;
        logic act;
        p = l * HT + h;
        x = h - 6;
        y = l - 2;
        @(posedge clk);
        #1;
        hs  = !(h < 3 && !(mode == 2 && l == 6));
        vs  = !(p >= vs_off && p < vs_off + 2 * HT);
        act = (l >= 2 && l < 2 + VA && h >= 6 && h < 6 + HA)
              && !(mode == 2 && l == 6) && !(mode == 1 && l == 4 && h == 5 + HA);
        blank = act;
        if (act)
          rgb = pat ? {8'(y), 8'(x), 8'hA5} : 24'h000001;
        else
          rgb = 24'd0;
        if (act && x == int'(sample_x) && y == int'(sample_y))
          tgt_cyc = cyc;
        if (p == rst_at) begin
          rst_n = 1'b0;
          #1;
          check("midrst_done",   frame_done,  0);
          check("midrst_locked", locked,      0);
          check("midrst_sum",    frame_sum,   0);
          check("midrst_sticky", err_sticky,  0);
          check("midrst_sample", sample_rgb,  0);
          check("midrst_lines",  frame_lines, 0);
          #2 rst_n = 1'b1;
        end
      end
    end
  endtask

  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",   frame_done,  0);
    check("rst_locked", locked,      0);
    check("rst_sum",    frame_sum,   0);
    check("rst_lines",  frame_lines, 0);
    check("rst_err",    frame_err,   0);
    check("rst_sticky", err_sticky,  0);
    check("rst_sample", sample_rgb,  0);
    check("rst_hit",    sample_hit,  0);
    check("rst_valid",  pix_valid,   0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // three nominal frames: first VS only arms
    base = done_cnt;
    run_frame(0, 4, -1);
    check("arm_no_done", done_cnt - base, 0);
    run_frame(0, 4, -1);
    check("f1_done_cnt", done_cnt - base, 1);
    check("f1_sum",      d_sum,    24'h000080);
    check("f1_lines",    d_lines,  8);
    check("f1_err",      d_err,    0);
    check("f1_locked",   d_locked, 0);
    run_frame(0, 4, -1);
    check("f2_done_cnt", done_cnt - base, 2);
    check("f2_sum",      d_sum,    24'h000080);
    check("f2_locked",   d_locked, 1);
    check("f2_sticky",   d_sticky, 0);

    // one short active line
    run_frame(1, 4, -1);
    run_frame(0, 4, -1);
    check("short_err",    d_err,    4'b0001);
    check("short_locked", d_locked, 0);
    check("short_sticky", d_sticky, 4'b0001);
    check("short_sum",    d_sum,    24'h00007F);
    check("short_lines",  d_lines,  8);
    run_frame(0, 4, -1);
    check("relock1_err",    d_err,    0);
    check("relock1_locked", d_locked, 0);
    check("relock1_sticky", d_sticky, 4'b0001);
    run_frame(0, 4, -1);
    check("relock2_locked", d_locked, 1);
    check("relock2_sticky", d_sticky, 4'b0001);

    // dropped HS pulse: one double-length line, one fewer active line
    run_frame(2, 4, -1);
    run_frame(0, 4, -1);
    check("drophs_err",    d_err,    4'b1110);
    check("drophs_lines",  d_lines,  7);
    check("drophs_sum",    d_sum,    24'h000070);
    check("drophs_locked", d_locked, 0);
    check("drophs_sticky", d_sticky, 4'b1111);

    // pixel capture with coordinate-encoded colour
    pat  = 1'b1;
    base = hit_cnt;
    run_frame(0, 4, -1);
    check("smp_hits",  hit_cnt - base, 1);
    check("smp_rgb",   hit_rgb, 24'h050AA5);
    check("smp_lat",   hit_lat, 3);
    check("pix_valid", s_valid, 1);
    check("pix_x",     s_x,     10);
    check("pix_y",     s_y,     5);
    check("pix_rgb",   s_rgb,   24'h050AA5);
    sample_y = 9'd100;
    base = hit_cnt;
    run_frame(0, 4, -1);
    check("nomatch_hits", hit_cnt - base, 0);
    check("nomatch_rgb",  sample_rgb, 24'h050AA5);
    pat = 1'b0;
    sample_y = 9'd5;

    // reset at line 4, then re-arm and measure again
    run_frame(0, 4, 4 * HT);
    base = done_cnt;
    run_frame(0, 4, -1);
    check("rearm_no_done", done_cnt - base, 0);
    run_frame(0, 4, -1);
    check("rearm_done_cnt", done_cnt - base, 1);
    check("rearm_err",      d_err,    0);
    check("rearm_sum",      d_sum,    24'h000080);
    check("rearm_sticky",   d_sticky, 0);
    check("rearm_locked",   d_locked, 0);

    // switch to HS/VS coincident; the transition frame sees only 11 line starts
    run_frame(0, 0, -1);
    check("trans_err", d_err, 4'b1000);
    run_frame(0, 0, -1);
    check("coinc_err",    d_err,    0);
    check("coinc_lines",  d_lines,  8);
    check("coinc_locked", d_locked, 0);
    run_frame(0, 0, -1);
    check("coinc2_err",    d_err,    0);
    check("coinc2_locked", d_locked, 1);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
